// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-prompt generator: FSM encoding,
// LFSR constants and the LFSR step function.
package reaction_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_DELAY = 3'd1,
        PROMPT     = 3'd2,
        DONE       = 3'd3,
        FAULT      = 3'd4
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shift Galois mask for x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int DEFAULT_CLK_PER_MS = 10000;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
    endfunction

endpackage

// File: rtl/reaction_prompt_gen_if.sv
// Player-facing signal bundle: start/button in, prompt LED and result flags out.
interface reaction_prompt_gen_if;
    logic       start;
    logic       button;
    logic       led_on;
    logic       hit;
    logic       false_start;
    logic       timeout;
    logic       busy;
    logic [2:0] state_o;

    modport master (
        output start, button,
        input  led_on, hit, false_start, timeout, busy, state_o
    );

    modport slave (
        input  start, button,
        output led_on, hit, false_start, timeout, busy, state_o
    );
endinterface

// File: rtl/reaction_prompt_gen_sync_edge.sv
// Two-flop synchroniser followed by a registered rising-edge detector;
// the rise pulse appears three clocks after the pin changes.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise
);
    logic meta;
    logic stable;
    logic stable_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta     <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            rise     <= 1'b0;
        end else begin
            meta     <= sig;
            stable   <= meta;
            stable_d <= stable;
            rise     <= stable & ~stable_d;
        end
    end
endmodule

// File: rtl/reaction_prompt_gen.sv
// Reaction-test prompt generator: random arm-to-prompt delay, prompt window
// with timeout, and classification of the press as hit or false start.
module reaction_prompt_gen
    import reaction_pkg::*;
#(
    parameter int CLK_PER_MS   = DEFAULT_CLK_PER_MS,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 10,
    parameter int TIMEOUT_MS   = 2000
) (
    input logic clk,
    input logic rst_n,
    reaction_prompt_gen_if.slave bus
);
    localparam int DELAY_MAX = MIN_DELAY_MS + (1 << RAND_BITS) - 1;
    localparam int DELAY_W   = $clog2(DELAY_MAX + 1);
    localparam int TO_W      = $clog2(TIMEOUT_MS + 1);
    localparam int PRE_W     = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int RAND_MASK = (1 << RAND_BITS) - 1;

    state_t             state;
    state_t             state_next;
    logic               start_rise;
    logic               button_rise;
    logic [PRE_W-1:0]   pre;
    logic               ms_tick;
    logic [DELAY_W-1:0] delay_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic [15:0]        lfsr;
    logic               arm;
    logic               set_hit;
    logic               set_false;
    logic               set_timeout;
    logic               hit_r;
    logic               false_r;
    logic               timeout_r;

    sync_edge u_start_sync  (.clk(clk), .rst_n(rst_n), .sig(bus.start),  .rise(start_rise));
    sync_edge u_button_sync (.clk(clk), .rst_n(rst_n), .sig(bus.button), .rise(button_rise));

    assign ms_tick = (pre == PRE_W'(CLK_PER_MS - 1));

    // Button is tested before the tick so a tie resolves to false start in
    // WAIT_DELAY and to hit in PROMPT.
    always_comb begin
        state_next  = state;
        arm         = 1'b0;
        set_hit     = 1'b0;
        set_false   = 1'b0;
        set_timeout = 1'b0;
        case (state)
            IDLE, DONE, FAULT: begin
                if (start_rise) begin
                    arm        = 1'b1;
                    state_next = WAIT_DELAY;
                end
            end
            WAIT_DELAY: begin
                if (button_rise) begin
                    set_false  = 1'b1;
                    state_next = FAULT;
                end else if (ms_tick && delay_cnt == DELAY_W'(1)) begin
                    state_next = PROMPT;
                end
            end
            PROMPT: begin
                if (button_rise) begin
                    set_hit    = 1'b1;
                    state_next = DONE;
                end else if (ms_tick && to_cnt == TO_W'(TIMEOUT_MS - 1)) begin
                    set_timeout = 1'b1;
                    state_next  = FAULT;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pre       <= '0;
            delay_cnt <= '0;
            to_cnt    <= '0;
            lfsr      <= LFSR_SEED;
            hit_r     <= 1'b0;
            false_r   <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state <= state_next;
            lfsr  <= lfsr_next(lfsr);

            // Every state entry restarts the millisecond phase
            if (state_next != state || ms_tick)
                pre <= '0;
            else
                pre <= pre + PRE_W'(1);

            if (arm)
                delay_cnt <= DELAY_W'(MIN_DELAY_MS) + DELAY_W'(lfsr & 16'(RAND_MASK));
            else if (state == WAIT_DELAY && ms_tick)
                delay_cnt <= delay_cnt - DELAY_W'(1);

            if (state == PROMPT && state_next == PROMPT)
                to_cnt <= ms_tick ? to_cnt + TO_W'(1) : to_cnt;
            else
                to_cnt <= '0;

            hit_r     <= set_hit;
            false_r   <= arm ? 1'b0 : (set_false | false_r);
            timeout_r <= arm ? 1'b0 : (set_timeout | timeout_r);
        end
    end

    assign bus.led_on      = (state == PROMPT);
    assign bus.busy        = (state == WAIT_DELAY) || (state == PROMPT);
    assign bus.hit         = hit_r;
    assign bus.false_start = false_r;
    assign bus.timeout     = timeout_r;
    assign bus.state_o     = state;
endmodule

// File: doc/reaction_prompt_gen.md
REACTION_PROMPT_GEN -- requirements
Module: reaction_prompt_gen

Interface
REQ-001 Parameter CLK_PER_MS, default 10000: clk cycles per 1 ms tick.
REQ-002 Parameter MIN_DELAY_MS, default 1000: minimum arm-to-prompt delay in ms.
REQ-003 Parameter RAND_BITS, default 10, range 0..12: LFSR bits added to the delay; 0 gives a fixed delay.
REQ-004 Parameter TIMEOUT_MS, default 2000: maximum prompt duration in ms.
REQ-005 One clock; reset is synchronous and active-low.
REQ-006 clk  input  1  system clock.
REQ-007 rst_n  input  1  synchronous active-low reset.
REQ-008 start  input  1  asynchronous level; a rising edge arms a trial.
REQ-009 button  input  1  asynchronous level; player button; a rising edge is a press.
REQ-010 led_on  output  1  prompt LED; this is the stimulus consumed by the reaction timer.
REQ-011 hit  output  1  one-cycle pulse when a valid press ends the prompt.
REQ-012 false_start  output  1  sticky; press occurred before the prompt.
REQ-013 timeout  output  1  sticky; no press occurred within TIMEOUT_MS.
REQ-014 busy  output  1  high in WAIT_DELAY and PROMPT.
REQ-015 state_o  output  3  current state encoding, for debug.

Function
REQ-016 Synchronisation: start and button each SHALL pass through a 2-FF synchroniser; edge detection on the synchronised signal gives a one-cycle rise pulse 3 clk after the pin edge.
REQ-017 Tick prescaler: ms_tick SHALL pulse one cycle every CLK_PER_MS cycles; the prescaler SHALL clear whenever a state is entered.
REQ-018 LFSR: 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1, seed 0xACE1, advances every clk and is never zero.
REQ-019 States: IDLE=0, WAIT_DELAY=1, PROMPT=2, DONE=3, FAULT=4; other encodings SHALL return to IDLE on the next clk.
REQ-020 IDLE or DONE or FAULT with a start rise: load delay_cnt = MIN_DELAY_MS + lfsr[RAND_BITS-1:0], clear hit, false_start and timeout, then go to WAIT_DELAY.
REQ-021 WAIT_DELAY: delay_cnt SHALL decrement on each ms_tick.
REQ-022 WAIT_DELAY exit: on ms_tick with delay_cnt==1, go to PROMPT, and led_on SHALL assert on the following cycle.
REQ-023 WAIT_DELAY with a button rise: go to FAULT and set false_start=1; led_on SHALL never assert.
REQ-024 PROMPT: led_on=1 and to_cnt counts ms_ticks from 0.
REQ-025 PROMPT with a button rise: go to DONE, pulse hit for one cycle, and drop led_on on the next cycle.
REQ-026 PROMPT with to_cnt reaching TIMEOUT_MS: go to FAULT, set timeout=1 and drop led_on.
REQ-027 Simultaneous events:
- Button rise in the same cycle as delay expiry: false start wins.
- Button rise in the same cycle as timeout: hit wins.
REQ-028 A start rise while busy=1 SHALL be ignored.
REQ-029 A button held high across the arm edge SHALL NOT count as a press; only a rise counts.
REQ-030 Counter widths SHALL be sized with $clog2 of their maximum value; there is no wrap in the legal range.

Reset
REQ-031 On rst_n=0 at a clk edge, all of the following SHALL hold on the next cycle, regardless of the current state:
- state=IDLE
- led_on=0, hit=0, false_start=0, timeout=0, busy=0
- all counters 0
- LFSR=0xACE1
- synchroniser and edge registers 0
REQ-032 Reset mid-PROMPT SHALL drop led_on on the next cycle.

Structure
REQ-033 A shared package reaction_pkg SHALL hold:
- the state enum/localparams
- LFSR seed and taps
- default CLK_PER_MS
REQ-034 One sub-module sync_edge (2-FF synchroniser plus rise detector) SHALL be instantiated twice, once for start and once for button.

Verification
REQ-035 Bench parameters: CLK_PER_MS=4, MIN_DELAY_MS=2, RAND_BITS=0, TIMEOUT_MS=8.
REQ-036 Normal trial: start rise, no press -> led_on rises 8±1 clk after the synchronised start edge; with a press 5 ms later -> hit pulses once, led_on falls, state_o=3.
REQ-037 False start: start, then button rise after 1 ms -> false_start=1, state_o=4, and led_on stays 0 for the rest of the test.
REQ-038 Timeout: start, never press -> led_on high for 32 clk, then timeout=1, led_on=0, state_o=4.
REQ-039 Boundaries:
- Button rise forced on the delay-expiry cycle -> false_start.
- Button rise on the timeout cycle -> hit.
- Start pulse while busy -> no change.
REQ-040 Reset mid-PROMPT -> next cycle: led_on=0, state_o=0, all flags 0; with RAND_BITS=10, 1000 trials -> delay always within [2, 1025] ms.
